// File: rtl/mem_access_if.sv
// Request/response handshake and DataMemory bus of mem_access_unit.
// slave = the unit, master = datapath plus memory side.
interface mem_access_if #(
   parameter int ADDR_W = 15
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W+1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] data_address;
   logic              write_en;
   logic [31:0]       write_data;
   logic [31:0]       read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned,
      input  req_addr, req_wdata, read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output data_address, write_en, write_data
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned,
      output req_addr, req_wdata, read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  data_address, write_en, write_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer in front of a word-wide DataMemory.
// MISALIGN_CHECK_EN: report misaligned requests instead of force-aligning.
module mem_access_unit #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         rst_n,
   mem_access_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

   state_e              state_q, state_d;
   logic                write_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [1:0]          off_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   word_q;
   logic                err_q;
   logic [ADDR_W-1:0]   daddr_q;

   logic                acc;
   logic                err_in;
   logic [ADDR_W+1:0]   addr_in;
   logic [4:0]          sh_b;
   logic [4:0]          sh_h;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [DATA_W-1:0]   load_d;
   logic [DATA_W-1:0]   wr_d;
   logic [DATA_W-1:0]   mask_d;
   logic [DATA_W-1:0]   ins_d;

   assign acc = bus.req_valid & bus.req_ready;

`ifdef MISALIGN_CHECK_EN
   logic mis;
   assign mis = (bus.req_size == 2'b01 & bus.req_addr[0])
              | (bus.req_size[1] & |bus.req_addr[1:0]);
   assign err_in = mis;
`else
   assign err_in = 1'b0;
`endif

   always_comb begin
      addr_in = bus.req_addr;
`ifndef MISALIGN_CHECK_EN
      // misaligned half/word requests drop the offending low bits
      if (bus.req_size[1]) addr_in[1:0] = 2'b00;
      else if (bus.req_size[0]) addr_in[0] = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               if (err_in) state_d = RESP;
               else if (bus.req_write && bus.req_size[1]) state_d = WR;
               else state_d = RD;
            end
         end
         RD:      state_d = write_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         wdata_q <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
         daddr_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            write_q <= bus.req_write;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= addr_in[1:0];
            wdata_q <= bus.req_wdata;
            err_q   <= err_in;
            if (!err_in) daddr_q <= addr_in[ADDR_W+1:2];
         end
         if (state_q == RD) word_q <= bus.read_data;
      end
   end

   assign sh_b   = {off_q, 3'b000};
   assign sh_h   = {off_q[1], 4'b0000};
   assign lane_b = 8'(word_q >> sh_b);
   assign lane_h = 16'(word_q >> sh_h);

   always_comb begin
      load_d = word_q;
      mask_d = '0;
      ins_d  = '0;
      unique case (1'b1)
         size_q[1]: begin
            load_d = word_q;
         end
         size_q == 2'b01: begin
            load_d = {{(DATA_W-16){~uns_q & lane_h[15]}}, lane_h};
            mask_d = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_h;
            ins_d  = {{(DATA_W-16){1'b0}}, wdata_q[15:0]} << sh_h;
         end
         size_q == 2'b00: begin
            load_d = {{(DATA_W-8){~uns_q & lane_b[7]}}, lane_b};
            mask_d = {{(DATA_W-8){1'b0}}, 8'hFF} << sh_b;
            ins_d  = {{(DATA_W-8){1'b0}}, wdata_q[7:0]} << sh_b;
         end
         default: begin
            load_d = word_q;
         end
      endcase
   end

   // word stores bypass the merge; sub-word stores patch the captured word
   assign wr_d = size_q[1] ? wdata_q : ((word_q & ~mask_d) | ins_d);

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.resp_valid   = (state_q == RESP);
   assign bus.write_en     = (state_q == WR);
   assign bus.data_address = daddr_q;
   assign bus.write_data   = wr_d;
   assign bus.resp_rdata   = (state_q == RESP && !write_q && !err_q)
                           ? load_d : '0;
`ifdef MISALIGN_CHECK_EN
   assign bus.resp_err     = (state_q == RESP) & err_q;
`else
   assign bus.resp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide memory model.
// Expectations follow MISALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   mem_access_if #(.ADDR_W(15)) bus ();

   mem_access_unit #(.ADDR_W(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:32767];

   assign bus.read_data = mem[bus.data_address];

   always @(posedge clk)
      if (bus.write_en) mem[bus.data_address] <= bus.write_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [1:0] sz,
                       input logic u, input logic [16:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output logic e,
                       output int lat, output int nwe,
                       output logic [14:0] wa, output logic [31:0] wv);
      int g;
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      bus.req_valid    = 1'b1;
      g = 0;
      while (!bus.req_ready && g < 10) begin
         @(negedge clk);
         g++;
      end
      if (g >= 10) check("accept_timeout", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = 17'($urandom);
      bus.req_wdata    = $urandom;
      lat = 1;
      nwe = 0;
      wa  = '0;
      wv  = '0;
      @(negedge clk);
      while (!bus.resp_valid && lat < 10) begin
         if (bus.write_en) begin
            nwe++;
            wa = bus.data_address;
            wv = bus.write_data;
         end
         @(negedge clk);
         lat++;
      end
      if (bus.write_en) nwe++;
      if (!bus.resp_valid) check("resp_timeout", 32'(bus.resp_valid), 32'd1);
      rd = bus.resp_rdata;
      e  = bus.resp_err;
   endtask

   task automatic st(input logic [16:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        e;
      int          lat, nwe;
      logic [14:0] wa;
      logic [31:0] wv;
      xfer(1'b1, 2'b10, 1'b0, a, d, rd, e, lat, nwe, wa, wv);
   endtask

   task automatic ld(input logic [1:0] sz, input logic u,
                     input logic [16:0] a, output logic [31:0] rd);
      logic        e;
      int          lat, nwe;
      logic [14:0] wa;
      logic [31:0] wv;
      xfer(1'b0, sz, u, a, 32'h0, rd, e, lat, nwe, wa, wv);
   endtask

   logic [31:0] rd, wv;
   logic        e;
   int          lat, nwe;
   logic [14:0] wa;
   logic        rdy [1:6];
   logic        rv  [1:6];
   logic        we  [1:6];
   logic [31:0] wdo [1:6];
   logic [31:0] rdo [1:6];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      #3;
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      check("rst_err", 32'(bus.resp_err), 32'd0);
      check("rst_we", 32'(bus.write_en), 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      check("rst_daddr", 32'(bus.data_address), 32'd0);
      check("rst_wdata", bus.write_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // word store then load
      xfer(1'b1, 2'b10, 1'b0, 17'h0004, 32'h12345678, rd, e, lat, nwe, wa, wv);
      check("wst_lat", 32'(lat), 32'd2);
      check("wst_nwe", 32'(nwe), 32'd1);
      check("wst_addr", 32'(wa), 32'd1);
      check("wst_data", wv, 32'h12345678);
      check("wst_rdata", rd, 32'h0);
      check("wst_err", 32'(e), 32'd0);
      xfer(1'b0, 2'b10, 1'b0, 17'h0004, 32'h0, rd, e, lat, nwe, wa, wv);
      check("wld_data", rd, 32'h12345678);
      check("wld_lat", 32'(lat), 32'd2);
      check("wld_nwe", 32'(nwe), 32'd0);

      st(17'h0008, 32'hABCDEF01);
      st(17'h000C, 32'h98765432);
      st(17'h0010, 32'h11223344);
      st(17'h0018, 32'hCAFEBABE);

      // byte store read-modify-write
      xfer(1'b1, 2'b00, 1'b0, 17'h000A, 32'hFFFFFF55, rd, e, lat, nwe, wa, wv);
      check("bst_data", wv, 32'hAB55EF01);
      check("bst_lat", 32'(lat), 32'd3);
      check("bst_nwe", 32'(nwe), 32'd1);
      check("bst_addr", 32'(wa), 32'd2);
      ld(2'b10, 1'b0, 17'h0008, rd);
      check("bst_back", rd, 32'hAB55EF01);

      // half store to upper lane
      xfer(1'b1, 2'b01, 1'b0, 17'h001A, 32'hFFFF1234, rd, e, lat, nwe, wa, wv);
      check("hst_data", wv, 32'h1234BABE);
      check("hst_lat", 32'(lat), 32'd3);
      ld(2'b10, 1'b0, 17'h0018, rd);
      check("hst_back", rd, 32'h1234BABE);

      // extension on loads
      ld(2'b01, 1'b0, 17'h000E, rd);
      check("lh_s_hi", rd, 32'hFFFF9876);
      ld(2'b01, 1'b1, 17'h000E, rd);
      check("lh_u_hi", rd, 32'h00009876);
      ld(2'b01, 1'b0, 17'h000C, rd);
      check("lh_s_lo", rd, 32'h00005432);
      ld(2'b00, 1'b0, 17'h000C, rd);
      check("lb_s_0", rd, 32'h00000032);
      ld(2'b00, 1'b1, 17'h000D, rd);
      check("lb_u_1", rd, 32'h00000054);
      ld(2'b00, 1'b0, 17'h000F, rd);
      check("lb_s_3", rd, 32'hFFFFFF98);
      ld(2'b00, 1'b1, 17'h000F, rd);
      check("lb_u_3", rd, 32'h00000098);
      ld(2'b11, 1'b0, 17'h0004, rd);
      check("lw_sz11", rd, 32'h12345678);

      // misaligned requests
      xfer(1'b0, 2'b10, 1'b0, 17'h0005, 32'h0, rd, e, lat, nwe, wa, wv);
`ifdef MISALIGN_CHECK_EN
      check("mis_err", 32'(e), 32'd1);
      check("mis_rdata", rd, 32'h0);
      check("mis_lat", 32'(lat), 32'd1);
`else
      check("mis_err", 32'(e), 32'd0);
      check("mis_rdata", rd, 32'h12345678);
      check("mis_lat", 32'(lat), 32'd2);
`endif
      check("mis_nwe", 32'(nwe), 32'd0);
      xfer(1'b1, 2'b01, 1'b0, 17'h0019, 32'h0000BEEF, rd, e, lat, nwe, wa, wv);
      ld(2'b10, 1'b0, 17'h0018, wv);
`ifdef MISALIGN_CHECK_EN
      check("mis_st_err", 32'(e), 32'd1);
      check("mis_st_nwe", 32'(nwe), 32'd0);
      check("mis_st_mem", wv, 32'h1234BABE);
`else
      check("mis_st_err", 32'(e), 32'd0);
      check("mis_st_nwe", 32'(nwe), 32'd1);
      check("mis_st_mem", wv, 32'h1234BEEF);
`endif

      // request held valid through a busy sub-word store
      @(negedge clk);
      bus.req_write    = 1'b1;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 17'h0010;
      bus.req_wdata    = 32'h000000AA;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_addr     = 17'h0010;
      bus.req_wdata    = 32'h0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         rdy[i] = bus.req_ready;
         rv[i]  = bus.resp_valid;
         we[i]  = bus.write_en;
         wdo[i] = bus.write_data;
         rdo[i] = bus.resp_rdata;
         if (i == 4) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
         end
      end
      check("busy_rdy1", 32'(rdy[1]), 32'd0);
      check("busy_rdy2", 32'(rdy[2]), 32'd0);
      check("busy_rdy3", 32'(rdy[3]), 32'd0);
      check("busy_rdy4", 32'(rdy[4]), 32'd1);
      check("busy_we2", 32'(we[2]), 32'd1);
      check("busy_wd2", wdo[2], 32'h112233AA);
      check("busy_rv3", 32'(rv[3]), 32'd1);
      check("busy_rv5", 32'(rv[5]), 32'd0);
      check("busy_rv6", 32'(rv[6]), 32'd1);
      check("busy_rd6", rdo[6], 32'h112233AA);

      // reset while in RD
      @(negedge clk);
      bus.req_write    = 1'b1;
      bus.req_size     = 2'b00;
      bus.req_addr     = 17'h0010;
      bus.req_wdata    = 32'h00000077;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rrd_daddr", 32'(bus.data_address), 32'd4);
      rst_n = 1'b0;
      #1;
      check("rrd_ready", 32'(bus.req_ready), 32'd1);
      check("rrd_we", 32'(bus.write_en), 32'd0);
      check("rrd_daddr0", 32'(bus.data_address), 32'd0);
      check("rrd_wdata", bus.write_data, 32'd0);
      check("rrd_rvalid", 32'(bus.resp_valid), 32'd0);
      nwe = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.write_en) nwe++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.write_en) nwe++;
      end
      check("rrd_nwe", 32'(nwe), 32'd0);
      ld(2'b10, 1'b0, 17'h0010, rd);
      check("rrd_mem", rd, 32'h112233AA);

      // top word address
      xfer(1'b1, 2'b10, 1'b0, 17'h1FFFC, 32'hFFFFFFFF, rd, e, lat, nwe, wa, wv);
      check("top_addr", 32'(wa), 32'h7FFF);
      check("top_nwe", 32'(nwe), 32'd1);
      ld(2'b10, 1'b0, 17'h1FFFC, rd);
      check("top_back", rd, 32'hFFFFFFFF);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
